// File: rtl/exmem_wb_ctrl_pkg.sv
// Shared types and defaults for the execution-memory Wishbone window.
package exmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/exmem_wb_ctrl_if.sv
// Wishbone classic slave-side bundle for the execution-memory window.
interface exmem_wb_ctrl_if;
  import exmem_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [31:0]       adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/exmem_bram_sp.sv
// Single-port byte-writable BRAM with 1-cycle synchronous read (old data on write).
module exmem_bram_sp #(
  parameter int WORD_AW = 10
) (
  input  logic               clk,
  input  logic               en,
  input  logic [3:0]         we,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**WORD_AW];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/exmem_wb_ctrl.sv
// Wishbone slave fronting a synchronous BRAM with a fixed number of wait states,
// giving firmware a deterministic access latency.
module exmem_wb_ctrl
  import exmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int          DELAYS    = 10,
  parameter int          WORD_AW   = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  exmem_wb_ctrl_if.slave     wbs,
  output logic               bram_en_o,
  output logic [3:0]         bram_we_o,
  output logic [WORD_AW-1:0] bram_addr_o,
  output logic [DATA_W-1:0]  bram_wdata_o,
  input  logic [DATA_W-1:0]  bram_rdata_i
);

  localparam logic [7:0] LAST_CNT = 8'(DELAYS - 1);

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic [WORD_AW-1:0]  adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [3:0]          sel_q;
  logic                we_q;
  logic                req;

  assign req = wbs.cyc & wbs.stb & addr_hit(wbs.adr, BASE_ADDR, ADDR_MASK);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        adr_q <= wbs.adr[WORD_AW+1:2];
        dat_q <= wbs.dat_w;
        sel_q <= wbs.sel;
        we_q  <= wbs.we;
        cnt   <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    bram_en_o = 1'b0;
    bram_we_o = '0;
    wbs.ack   = 1'b0;
    wbs.dat_r = '0;
    unique case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        if (!wbs.cyc) begin
          state_nxt = IDLE;
        end else if (cnt == LAST_CNT) begin
          bram_en_o = 1'b1;
          bram_we_o = we_q ? sel_q : 4'b0000;
          state_nxt = ACK;
        end
      end
      ACK: begin
        wbs.ack   = wbs.cyc;
        wbs.dat_r = we_q ? '0 : bram_rdata_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset also masks the cycle in which it is first sampled, so a pending
    // write never reaches the BRAM.
    if (wb_rst_i) begin
      bram_en_o = 1'b0;
      bram_we_o = '0;
      wbs.ack   = 1'b0;
      wbs.dat_r = '0;
    end
  end

  assign bram_addr_o  = adr_q;
  assign bram_wdata_o = dat_q;

endmodule
